// File: rtl/serial_divider.sv
// Restoring shift-subtract divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock.
// Optional build macro SIGNED_DIV_EN selects two's-complement operands; the default build is purely unsigned.
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   DVD,
    input  logic [WIDTH-1:0]     DVS,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     R,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   lo_r;      // low dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   r_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic               ovf_r;
    logic               fast_dbz_r;

    logic [2*WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0]   dvs_mag_s;
    logic               dvs_zero_s;
    logic               fast_ovf_s;
    logic               accept_s;
    logic [WIDTH:0]     trial_s;
    logic               ge_s;
    logic [WIDTH-1:0]   rem_nx_s;
    logic [WIDTH-1:0]   quo_nx_s;
    logic [WIDTH-1:0]   fin_q_s;
    logic [WIDTH-1:0]   fin_r_s;
    logic               fin_ovf_s;

`ifdef SIGNED_DIV_EN
    logic               dvd_neg_s;
    logic               dvs_neg_s;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   q_lim_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // operand magnitudes and signs taken at accept time
    always_comb begin
        dvd_neg_s = DVD[2*WIDTH-1];
        dvs_neg_s = DVS[WIDTH-1];
        if (dvd_neg_s) begin
            dvd_mag_s = neg_dw(DVD);
        end else begin
            dvd_mag_s = DVD;
        end
        if (dvs_neg_s) begin
            dvs_mag_s = neg_w(DVS);
        end else begin
            dvs_mag_s = DVS;
        end
    end
`else
    assign dvd_mag_s = DVD;
    assign dvs_mag_s = DVS;
`endif

    assign dvs_zero_s = (DVS == W_ZERO);
    // quotient cannot fit in WIDTH bits when the upper dividend half already reaches the divisor
    assign fast_ovf_s = (dvd_mag_s[2*WIDTH-1:WIDTH] >= dvs_mag_s);
    assign accept_s   = start & ~busy_r & ((state_r == ST_IDLE) | (state_r == ST_FIN));

    // one restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial_s = {rem_r, lo_r[WIDTH-1]};
        ge_s    = (trial_s >= {1'b0, dvs_r});
        if (ge_s) begin
            rem_nx_s = trial_s[WIDTH-1:0] - dvs_r;
        end else begin
            rem_nx_s = trial_s[WIDTH-1:0];
        end
        quo_nx_s = {lo_r[WIDTH-2:0], ge_s};
    end

`ifdef SIGNED_DIV_EN
    // sign fix-up and signed range check on the last quotient bit
    always_comb begin
        if (neg_q_r) begin
            q_lim_s = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            q_lim_s = {1'b0, {(WIDTH-1){1'b1}}};
        end
        if (quo_nx_s > q_lim_s) begin
            fin_q_s   = W_ONES;
            fin_r_s   = W_ZERO;
            fin_ovf_s = 1'b1;
        end else begin
            fin_q_s   = neg_q_r ? neg_w(quo_nx_s) : quo_nx_s;
            fin_r_s   = neg_r_r ? neg_w(rem_nx_s) : rem_nx_s;
            fin_ovf_s = 1'b0;
        end
    end

    // result sign flags captured with the operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (accept_s) begin
            neg_q_r <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r <= dvd_neg_s;
        end else begin
            neg_q_r <= neg_q_r;
            neg_r_r <= neg_r_r;
        end
    end
`else
    // unsigned results come straight from the core
    always_comb begin
        fin_q_s   = quo_nx_s;
        fin_r_s   = rem_nx_s;
        fin_ovf_s = 1'b0;
    end
`endif

    // sequencer, datapath registers and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            rem_r      <= W_ZERO;
            lo_r       <= W_ZERO;
            dvs_r      <= W_ZERO;
            q_r        <= W_ZERO;
            r_r        <= W_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            ovf_r      <= 1'b0;
            fast_dbz_r <= 1'b0;
        end else if (accept_s) begin
            state_r    <= (dvs_zero_s || fast_ovf_s) ? ST_FIN : ST_RUN;
            cnt_r      <= CNT_LOAD;
            rem_r      <= dvd_mag_s[2*WIDTH-1:WIDTH];
            // divide-by-zero reports the raw low dividend half as the remainder
            lo_r       <= dvs_zero_s ? DVD[WIDTH-1:0] : dvd_mag_s[WIDTH-1:0];
            dvs_r      <= dvs_mag_s;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            ovf_r      <= 1'b0;
            fast_dbz_r <= dvs_zero_s;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    rem_r <= rem_nx_s;
                    lo_r  <= quo_nx_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        q_r     <= fin_q_s;
                        r_r     <= fin_r_s;
                        ovf_r   <= fin_ovf_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FIN: begin
                    if (busy_r) begin
                        // fast-path completion one edge after accept
                        q_r     <= W_ONES;
                        r_r     <= fast_dbz_r ? lo_r : W_ZERO;
                        dbz_r   <= fast_dbz_r;
                        ovf_r   <= ~fast_dbz_r;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_FIN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_r;
    assign R    = r_r;
    assign busy = busy_r;
    assign done = done_r;
    assign dbz  = dbz_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed cases plus random operands against an arithmetic reference.
module tb_serial_divider;

    localparam int W = 32;
`ifdef SIGNED_DIV_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   DVD   = 64'd0;
    logic [31:0]   DVS   = 32'd0;
    logic [31:0]   Q;
    logic [31:0]   R;
    logic          busy;
    logic          done;
    logic          dbz;
    logic          ovf;

    int            total  = 0;
    int            bad    = 0;
    logic [31:0]   last_q = 32'd0;
    logic [31:0]   last_r = 32'd0;

    always #5 clk = ~clk;

    serial_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .DVD   (DVD),
        .DVS   (DVS),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // plain-arithmetic reference: quotient/remainder via / and %, flags from the range rules
    function automatic void ref_div(input logic [63:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov, output int lat);
        logic [63:0] ua, ub, qm, rm, lim;
        logic        na, nb;
        na = SGN & a[63];
        nb = SGN & b[31];
        ua = na ? (64'd0 - a) : a;
        ub = nb ? (64'd0 - {{32{b[31]}}, b}) : {32'd0, b};
        dz = 1'b0; ov = 1'b0; lat = W; q = 32'd0; r = 32'd0;
        if (b == 32'd0) begin
            dz = 1'b1; q = 32'hFFFF_FFFF; r = a[31:0]; lat = 1;
        end else begin
            qm  = ua / ub;
            rm  = ua % ub;
            lim = (na ^ nb) ? 64'h8000_0000 : 64'h7FFF_FFFF;
            if (qm > 64'hFFFF_FFFF) begin
                ov = 1'b1; q = 32'hFFFF_FFFF; r = 32'd0; lat = 1;
            end else if (SGN && (qm > lim)) begin
                ov = 1'b1; q = 32'hFFFF_FFFF; r = 32'd0;
            end else begin
                q = (na ^ nb) ? (32'd0 - qm[31:0]) : qm[31:0];
                r = na ? (32'd0 - rm[31:0]) : rm[31:0];
            end
        end
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] eq, er;
        logic        ed, eo;
        int          lat, n;
        bit          busy_bad;
        ref_div(a, b, eq, er, ed, eo, lat);
        @(negedge clk);
        DVD = a; DVS = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", {63'd0, busy}, 64'd1);
        check("q_held_on_accept", {32'd0, Q}, {32'd0, last_q});
        check("r_held_on_accept", {32'd0, R}, {32'd0, last_r});
        check("flags_clear_on_accept", {62'd0, dbz, ovf}, 64'd0);
        n = 0;
        busy_bad = 1'b0;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (poke && n == 3) begin
                DVD = 64'd50; DVS = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("busy_during_op", {63'd0, busy_bad}, 64'd0);
        check("quotient", {32'd0, Q}, {32'd0, eq});
        check("remainder", {32'd0, R}, {32'd0, er});
        check("dbz", {63'd0, dbz}, {63'd0, ed});
        check("ovf", {63'd0, ovf}, {63'd0, eo});
        check("busy_at_done", {63'd0, busy}, 64'd0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic [31:0] rb, rh;
        logic [63:0] ra;
        bit          seen;

        #12;
        check("reset_qr", {Q, R}, 64'd0);
        check("reset_flags", {60'd0, busy, done, dbz, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op(64'd100, 32'd7, 1'b0);
        do_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0);
        do_op(64'h1_0000_0000, 32'd1, 1'b0);
        do_op(64'h1234, 32'd0, 1'b0);
        do_op(64'd100, 32'd7, 1'b1);
        do_op(64'd9, 32'd2, 1'b0);
        do_op(64'd9, 32'd3, 1'b0);
`ifdef SIGNED_DIV_EN
        do_op(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 1'b0);
        do_op(64'd100, 32'hFFFF_FFF9, 1'b0);
        do_op(64'hC000_0000_0000_0000, 32'd1, 1'b0);
        do_op(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b0);
        do_op(64'h0000_0000_8000_0000, 32'd1, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
            rb = $urandom;
            if (i % 3 == 2) rb = $urandom_range(300, 1);
            if (i % 8 == 0) rb = 32'd0;
            rh = (rb != 32'd0) ? ($urandom % rb) : $urandom;
            ra = {rh, $urandom};
            if (i % 5 == 1) ra = {$urandom, $urandom};
            do_op(ra, rb, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("hold_done_low", {63'd0, done}, 64'd0);
        check("hold_q", {32'd0, Q}, {32'd0, last_q});

        do_op(64'd9, 32'd2, 1'b0);
        @(negedge clk);
        DVD = 64'd100; DVS = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        DVD = 64'd50; DVS = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_busy", {63'd0, busy}, 64'd1);
        check("ignored_start_done", {63'd0, done}, 64'd0);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midop_reset_qr", {Q, R}, 64'd0);
        check("midop_reset_flags", {60'd0, busy, done, dbz, ovf}, 64'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("no_done_in_reset", {63'd0, seen}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        last_q = 32'd0;
        last_r = 32'd0;
        do_op(64'd50, 32'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
